// File: rtl/ov7670_ds_pkg.sv
// Shared constants and types for the OV7670 luma box-average downscaler.
package ov7670_ds_pkg;

    localparam int IMG_W = 640;             // source pixels per line
    localparam int IMG_H = 480;             // source lines per frame
    localparam int BLK   = 20;              // square block edge, source pixels
    localparam int OUT_W = IMG_W / BLK;     // 32 reduced columns
    localparam int OUT_H = IMG_H / BLK;     // 24 reduced rows
    localparam int RECIP = 164;             // round(2^SHIFT / BLK^2)
    localparam int SHIFT = 16;

    // Block sum: at most 400 * 255 = 102000, fits in 17 bits.
    typedef logic [16:0] acc_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // between frames, waiting for vsync low
        ACCUM = 2'd1,   // summing blocks of the current frame
        DONE  = 2'd2    // reduced frame complete, ignoring pixels
    } ds_state_e;

endpackage

// File: rtl/ds_avg_scale.sv
// Block sum to 8-bit average: multiply by reciprocal, shift, saturate.
// Optional OV7670_DS_INVERT_EN produces 255 - average (white-on-black).
module ds_avg_scale
    import ov7670_ds_pkg::*;
(
    input  acc_t       i_sum,
    output logic [7:0] o_pix
);

    logic [24:0] w_prod;
    logic [24:0] w_shift;
    logic [7:0]  w_sat;

    // 17x8 multiply needs 25 bits; a full 400*255 sum lands on 255.2, hence the clamp.
    assign w_prod  = 25'(i_sum) * 25'(RECIP);
    assign w_shift = w_prod >> SHIFT;
    assign w_sat   = (w_shift > 25'd255) ? 8'd255 : w_shift[7:0];

`ifdef OV7670_DS_INVERT_EN
    assign o_pix = 8'd255 - w_sat;
`else
    assign o_pix = w_sat;
`endif

endmodule

// File: rtl/ov7670_downscale.sv
// Snoops the capture-stage framebuffer write stream and writes BLKxBLK luma
// box averages into fb2 (address by*OUT_W + bx), pulsing o_frame_done with the
// last block write. Build option: OV7670_DS_INVERT_EN (inverted output).
//
// Interface: i_pix_we is a one-cycle write strobe with no back-pressure; each
// high cycle carries one luma sample. o_out_we is a one-cycle strobe that
// follows the block-completing i_pix_we by exactly one pclk; o_out_addr and
// o_out_data are valid while o_out_we is high and hold their last value otherwise.
module ov7670_downscale
    import ov7670_ds_pkg::*;
#(
    parameter int P_IMG_W = IMG_W,
    parameter int P_IMG_H = IMG_H
)(
    input  logic        i_pclk,
    input  logic        i_rst_n,
    input  logic        i_vsync,
    input  logic        i_pix_we,
    input  logic [18:0] i_pix_addr,
    input  logic [7:0]  i_pix_data,
    output logic [9:0]  o_out_addr,
    output logic [7:0]  o_out_data,
    output logic        o_out_we,
    output logic        o_frame_done,
    output ds_state_e   o_dbg_state
);

    localparam int L_OUT_W = P_IMG_W / BLK;
    localparam int L_OUT_H = P_IMG_H / BLK;
    // Sized for the full-width build so a 5-bit column index always fits.
    localparam int L_ACC_N = 32;

    ds_state_e  r_state;
    logic [4:0] r_sx, r_bx, r_sy, r_by;
    acc_t       r_acc [L_ACC_N];

    acc_t       w_sum;
    logic [7:0] w_avg;
    logic       w_cnt_nz;
    logic       w_resync;
    logic       w_blk_done;

    // Running sum of the current column's block including the incoming sample.
    assign w_sum      = r_acc[r_bx] + acc_t'(i_pix_data);
    assign w_cnt_nz   = |{r_sx, r_bx, r_sy, r_by};
    assign w_resync   = (i_pix_addr == 19'd0) && w_cnt_nz;
    assign w_blk_done = (r_sx == 5'(BLK - 1)) && (r_sy == 5'(BLK - 1));
    assign o_dbg_state = r_state;

    ds_avg_scale u_avg (
        .i_sum (w_sum),
        .o_pix (w_avg)
    );

    // Frame FSM, position counters, column accumulators and registered fb2 write.
    always_ff @(posedge i_pclk) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_sx         <= '0;
            r_bx         <= '0;
            r_sy         <= '0;
            r_by         <= '0;
            for (int i = 0; i < L_ACC_N; i++) r_acc[i] <= '0;
            o_out_addr   <= '0;
            o_out_data   <= '0;
            o_out_we     <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_out_we     <= 1'b0;
            o_frame_done <= 1'b0;
            if (i_vsync) begin
                // Between frames: drop any partial frame without writing it out.
                r_state <= IDLE;
                r_sx    <= '0;
                r_bx    <= '0;
                r_sy    <= '0;
                r_by    <= '0;
                for (int i = 0; i < L_ACC_N; i++) r_acc[i] <= '0;
            end else begin
                case (r_state)
                    IDLE: r_state <= ACCUM;
                    ACCUM: begin
                        if (i_pix_we) begin
                            if (w_resync) begin
                                // Capture restarted at address 0: this sample is pixel (0,0).
                                for (int i = 0; i < L_ACC_N; i++) r_acc[i] <= '0;
                                r_acc[0] <= acc_t'(i_pix_data);
                                r_sx     <= 5'd1;
                                r_bx     <= '0;
                                r_sy     <= '0;
                                r_by     <= '0;
                            end else begin
                                if (w_blk_done) begin
                                    r_acc[r_bx] <= '0;
                                    o_out_we    <= 1'b1;
                                    o_out_addr  <= 10'(r_by) * 10'(L_OUT_W) + 10'(r_bx);
                                    o_out_data  <= w_avg;
                                end else begin
                                    r_acc[r_bx] <= w_sum;
                                end
                                if (r_sx == 5'(BLK - 1)) begin
                                    r_sx <= '0;
                                    if (r_bx == 5'(L_OUT_W - 1)) begin
                                        r_bx <= '0;
                                        if (r_sy == 5'(BLK - 1)) begin
                                            r_sy <= '0;
                                            if (r_by == 5'(L_OUT_H - 1)) begin
                                                r_by         <= '0;
                                                r_state      <= DONE;
                                                o_frame_done <= 1'b1;
                                            end else begin
                                                r_by <= r_by + 5'd1;
                                            end
                                        end else begin
                                            r_sy <= r_sy + 5'd1;
                                        end
                                    end else begin
                                        r_bx <= r_bx + 5'd1;
                                    end
                                end else begin
                                    r_sx <= r_sx + 5'd1;
                                end
                            end
                        end
                    end
                    DONE:    r_state <= DONE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ov7670_downscale.sv
// Bench for ov7670_downscale on a reduced 100x60 frame (5x3 blocks): constant,
// column and random frames, vsync abort, mid-block reset and address-0 resync.
`timescale 1ns/1ps
module tb_ov7670_downscale;

    localparam int W    = 100;
    localparam int H    = 60;
    localparam int BLK  = 20;
    localparam int OW   = W / BLK;
    localparam int OH   = H / BLK;
    localparam int NPIX = W * H;
    localparam int NBLK = OW * OH;
    localparam int K_CONST = 0;
    localparam int K_COL   = 1;
    localparam int K_RAND  = 2;

    typedef struct {
        int kind;       // image pattern
        int val;        // constant pixel value
        int gap;        // cycles per pixel, 0 = random 1..2
        int exp_out;    // expected output for constant frames
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b1;
    logic        pix_we = 1'b0;
    logic [18:0] pix_addr = '0;
    logic [7:0]  pix_data = '0;
    logic [9:0]  out_addr;
    logic [7:0]  out_data;
    logic        out_we;
    logic        frame_done;
    ov7670_ds_pkg::ds_state_e dbg_state;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int n_wr = 0;
    int n_fd = 0;
    int img [NPIX];
    int cur_kind = K_CONST;
    int cur_exp = 0;
    logic [18:0] exp_q [$];   // {frame_done, addr, data}
    int          lat_q [$];   // cycle on which out_we must be seen

    ov7670_downscale #(.P_IMG_W(W), .P_IMG_H(H)) dut (
        .i_pclk       (clk),
        .i_rst_n      (rst_n),
        .i_vsync      (vsync),
        .i_pix_we     (pix_we),
        .i_pix_addr   (pix_addr),
        .i_pix_data   (pix_data),
        .o_out_addr   (out_addr),
        .o_out_data   (out_data),
        .o_out_we     (out_we),
        .o_frame_done (frame_done),
        .o_dbg_state  (dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int inv(input int v);
`ifdef OV7670_DS_INVERT_EN
        return 255 - v;
`else
        return v;
`endif
    endfunction

    // Reference: arithmetic mean approximation floor(sum*164/65536), clamped.
    function automatic int model_avg(input int bx, input int by);
        longint sum;
        longint avg;
        sum = 0;
        for (int y = by * BLK; y < (by + 1) * BLK; y++)
            for (int x = bx * BLK; x < (bx + 1) * BLK; x++)
                sum += img[y * W + x];
        avg = (sum * 164) / 65536;
        if (avg > 255) avg = 255;
        return inv(int'(avg));
    endfunction

    function automatic int exp_for(input int bx, input int by);
        if (cur_kind == K_CONST) return cur_exp;
        if (cur_kind == K_COL)   return inv(8 * bx);
        return model_avg(bx, by);
    endfunction

    task automatic fill_img(input int kind, input int val);
        cur_kind = kind;
        for (int i = 0; i < NPIX; i++) begin
            if (kind == K_CONST)    img[i] = val;
            else if (kind == K_COL) img[i] = 8 * ((i % W) / BLK);
            else                    img[i] = int'($urandom_range(0, 255));
        end
    endtask

    // Driver: one pixel strobe, then gap-1 idle cycles
    task automatic drive_px(input int idx, input int gap);
        int x;
        int y;
        int bx;
        int by;
        logic fd;
        x = idx % W;
        y = idx / W;
        @(negedge clk);
        pix_we   = 1'b1;
        pix_addr = 19'(idx);
        pix_data = 8'(img[idx]);
        if ((x % BLK == BLK - 1) && (y % BLK == BLK - 1)) begin
            bx = x / BLK;
            by = y / BLK;
            fd = (bx == OW - 1) && (by == OH - 1);
            exp_q.push_back({fd, 10'(by * OW + bx), 8'(exp_for(bx, by))});
            lat_q.push_back(cyc + 1);
        end
        if (gap > 1) begin
            @(negedge clk);
            pix_we   = 1'b0;
            pix_data = 8'($urandom);
            pix_addr = 19'($urandom_range(1, 5000));
            repeat (gap - 2) @(negedge clk);
        end
    endtask

    task automatic drive_range(input int lo, input int hi, input int gap);
        for (int i = lo; i < hi; i++)
            drive_px(i, (gap == 0) ? int'($urandom_range(1, 2)) : gap);
        @(negedge clk);
        pix_we = 1'b0;
    endtask

    task automatic start_frame();
        @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        pix_we   = 1'b1;          // must be ignored while vsync is high
        pix_addr = 19'd5;
        pix_data = 8'd255;
        @(negedge clk);
        pix_we = 1'b0;
        repeat (2) @(negedge clk);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        check("state_accum", 32'(dbg_state), 32'(ov7670_ds_pkg::ACCUM));
    endtask

    // Full frame with end-of-frame bookkeeping, then pixels that DONE must ignore
    task automatic full_frame(input int gap, input bit do_vsync);
        int w0;
        int f0;
        if (do_vsync) start_frame();
        w0 = n_wr;
        f0 = n_fd;
        drive_range(0, NPIX, gap);
        repeat (3) @(negedge clk);
        check("frame_writes", n_wr - w0, NBLK);
        check("frame_done_count", n_fd - f0, 1);
        check("exp_q_drained", exp_q.size(), 0);
        check("state_done", 32'(dbg_state), 32'(ov7670_ds_pkg::DONE));
        w0 = n_wr;
        drive_range(0, 3, 1);
        repeat (3) @(negedge clk);
        check("done_ignores_pixels", n_wr - w0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_we"},     32'(out_we), 0);
        check({tag, "_frame_done"}, 32'(frame_done), 0);
        check({tag, "_out_addr"},   32'(out_addr), 0);
        check({tag, "_out_data"},   32'(out_data), 0);
        check({tag, "_state"},      32'(dbg_state), 32'(ov7670_ds_pkg::IDLE));
    endtask

    // Scoreboard: every fb2 write is matched against the expected queue
    initial begin
        logic [18:0] e;
        int l;
        forever begin
            @(negedge clk);
            if (out_we === 1'b1) begin
                n_wr++;
                if (frame_done === 1'b1) n_fd++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: addr=%0d data=%0d, no write required", out_addr, out_data);
                end else begin
                    e = exp_q.pop_front();
                    l = lat_q.pop_front();
                    check("wr_addr", 32'(out_addr), 32'(e[17:8]));
                    check("wr_data", 32'(out_data), 32'(e[7:0]));
                    check("wr_frame_done", 32'(frame_done), 32'(e[18]));
                    check("wr_latency_cycle", cyc, l);
                end
            end else if (frame_done === 1'b1) begin
                n_cmp++;
                n_err++;
                $display("FAIL frame_done_without_we: frame_done=1 out_we=%0b, required 0", out_we);
            end
        end
    end

    // Main sequence
    initial begin
        vec_t tbl [5];
        int w0;
        int f0;
        tbl[0] = '{K_CONST, 100, 2, inv(100)};
        tbl[1] = '{K_CONST, 255, 1, inv(255)};
        tbl[2] = '{K_CONST, 0,   1, inv(0)};
        tbl[3] = '{K_COL,   0,   1, 0};
        tbl[4] = '{K_RAND,  0,   0, 0};

        rst_n = 1'b0;
        vsync = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            cur_exp = tbl[i].exp_out;
            fill_img(tbl[i].kind, tbl[i].val);
            full_frame(tbl[i].gap, 1'b1);
        end

        // vsync abort after 40 lines: two block rows written, no frame_done
        fill_img(K_RAND, 0);
        start_frame();
        w0 = n_wr;
        f0 = n_fd;
        drive_range(0, 40 * W, 1);
        repeat (3) @(negedge clk);
        check("abort_writes", n_wr - w0, 2 * OW);
        check("abort_frame_done", n_fd - f0, 0);
        fill_img(K_RAND, 0);
        full_frame(1, 1'b1);

        // one-cycle reset in the middle of a block
        fill_img(K_RAND, 0);
        start_frame();
        w0 = n_wr;
        drive_range(0, 25 * W + 7, 1);
        repeat (3) @(negedge clk);
        check("pre_reset_writes", n_wr - w0, OW);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midblock_reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_state", 32'(dbg_state), 32'(ov7670_ds_pkg::ACCUM));
        fill_img(K_RAND, 0);
        full_frame(1, 1'b0);

        // resync: address 0 arrives at pixel 1000 of a frame
        fill_img(K_RAND, 0);
        start_frame();
        w0 = n_wr;
        drive_range(0, 1000, 1);
        repeat (3) @(negedge clk);
        check("pre_resync_writes", n_wr - w0, 0);
        fill_img(K_RAND, 0);
        full_frame(1, 1'b0);

        check("final_exp_q", exp_q.size(), 0);
        check("final_lat_q", lat_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
